// File: rtl/options_menu_ctl.sv
// Difficulty selector for the options screen: NUM_LEVELS stacked buttons, each with its own hit-test and click qualification.
// Latency: hover is valid 1 cycle after the mouse moves. A commit updates the level on the edge that samples the release.
// Backpressure: none. Mouse inputs are sampled every cycle. Optional keyboard navigation is enabled by OPTIONS_KEYS_EN.
module options_menu_ctl #(
    parameter int NUM_LEVELS    = 3,
    parameter int LEVEL_W       = 3,
    parameter int DEFAULT_LEVEL = 1,
    parameter int X_POS         = 200,
    parameter int Y_POS         = 150,
    parameter int WIDTH         = 240,
    parameter int HEIGHT        = 60,
    parameter int Y_SPACING     = 80,
    parameter int CARD_NUM_W    = 6,
    parameter int CARD_NUM_BASE = 8,
    parameter int CARD_NUM_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  mouse_left,
    input  logic [11:0]           mouse_xpos,
    input  logic [11:0]           mouse_ypos,
`ifdef OPTIONS_KEYS_EN
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  key_enter,
    output logic [LEVEL_W-1:0]    cursor_idx,
`endif
    output logic [LEVEL_W-1:0]    selected_level,
    output logic [CARD_NUM_W-1:0] num_of_cards,
    output logic                  level_changed,
    output logic                  hover_valid,
    output logic [LEVEL_W-1:0]    hover_idx,
    output logic                  pressed_idx_valid
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ARMED        = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    localparam logic [LEVEL_W-1:0] DEF_LVL  = LEVEL_W'(DEFAULT_LEVEL);
    localparam logic [LEVEL_W-1:0] LAST_LVL = LEVEL_W'(NUM_LEVELS - 1);

    function automatic logic [CARD_NUM_W-1:0] cards_for(input logic [LEVEL_W-1:0] lvl);
        return CARD_NUM_W'(CARD_NUM_BASE + int'(lvl) * CARD_NUM_STEP);
    endfunction

    state_t                  state_q, state_d;
    logic [LEVEL_W-1:0]      armed_idx_q, armed_idx_d;
    logic                    mouse_left_d_q;
    logic [LEVEL_W-1:0]      selected_level_q, selected_level_d;
    logic [CARD_NUM_W-1:0]   num_of_cards_q, num_of_cards_d;
    logic                    level_changed_q, level_changed_d;
    logic                    hover_valid_q, hover_valid_d;
    logic [LEVEL_W-1:0]      hover_idx_q, hover_idx_d;
    logic                    hit;
    logic [LEVEL_W-1:0]      hit_idx;
    logic                    rise;
    logic                    mouse_commit;
    logic                    commit;
    logic [LEVEL_W-1:0]      commit_idx;
`ifdef OPTIONS_KEYS_EN
    logic [LEVEL_W-1:0]      cursor_idx_q, cursor_idx_d;
`endif

    // Hit-test the live cursor against every button. The buttons are disjoint, so at most one can match.
    always_comb begin
        int x_i;
        int y_i;
        int top;
        hit     = 1'b0;
        hit_idx = '0;
        x_i     = int'(mouse_xpos);
        y_i     = int'(mouse_ypos);
        for (int i = 0; i < NUM_LEVELS; i++) begin
            top = Y_POS + i * Y_SPACING;
            if (x_i >= X_POS && x_i <= X_POS + WIDTH - 1 &&
                y_i >= top && y_i <= top + HEIGHT - 1) begin
                hit     = 1'b1;
                hit_idx = LEVEL_W'(i);
            end
        end
    end

    assign rise = mouse_left & ~mouse_left_d_q;

    // FSM state register, plus the armed button index that belongs to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            armed_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            armed_idx_q <= armed_idx_d;
        end
    end

    // Next-state logic. A click commits only when it is pressed and released on the same button.
    always_comb begin
        state_d      = state_q;
        armed_idx_d  = armed_idx_q;
        mouse_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && rise) begin
                    if (hit) begin
                        state_d     = ST_ARMED;
                        armed_idx_d = hit_idx;
                    end else begin
                        state_d = ST_WAIT_RELEASE;
                    end
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (!mouse_left) begin
                    state_d      = ST_IDLE;
                    mouse_commit = hit && (hit_idx == armed_idx_q);
                end
            end
            ST_WAIT_RELEASE: begin
                if (!mouse_left) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the pressed look is shown exactly while a button is armed.
    always_comb begin
        pressed_idx_valid = (state_q == ST_ARMED);
    end

    // Select the commit source. When the mouse and a key commit in the same cycle, the mouse wins.
    always_comb begin
        commit     = mouse_commit;
        commit_idx = armed_idx_q;
`ifdef OPTIONS_KEYS_EN
        cursor_idx_d = cursor_idx_q;
        if (mouse_commit) begin
            cursor_idx_d = armed_idx_q;
        end else if (enable) begin
            if (key_enter) begin
                commit     = 1'b1;
                commit_idx = cursor_idx_q;
            end
            if (key_up) begin
                cursor_idx_d = (cursor_idx_q == '0) ? LAST_LVL : cursor_idx_q - 1'b1;
            end else if (key_down) begin
                cursor_idx_d = (cursor_idx_q == LAST_LVL) ? '0 : cursor_idx_q + 1'b1;
            end
        end
`endif
    end

    // Selected level, card count, change strobe and registered hover information.
    always_comb begin
        selected_level_d = selected_level_q;
        num_of_cards_d   = num_of_cards_q;
        level_changed_d  = 1'b0;
        if (commit) begin
            selected_level_d = commit_idx;
            num_of_cards_d   = cards_for(commit_idx);
            level_changed_d  = (commit_idx != selected_level_q);
        end
        hover_valid_d = enable & hit;
        hover_idx_d   = (enable & hit) ? hit_idx : '0;
    end

    // Datapath registers. The level and the card count load together, so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mouse_left_d_q   <= 1'b0;
            selected_level_q <= DEF_LVL;
            num_of_cards_q   <= cards_for(DEF_LVL);
            level_changed_q  <= 1'b0;
            hover_valid_q    <= 1'b0;
            hover_idx_q      <= '0;
        end else begin
            mouse_left_d_q   <= mouse_left;
            selected_level_q <= selected_level_d;
            num_of_cards_q   <= num_of_cards_d;
            level_changed_q  <= level_changed_d;
            hover_valid_q    <= hover_valid_d;
            hover_idx_q      <= hover_idx_d;
        end
    end

`ifdef OPTIONS_KEYS_EN
    // Keyboard cursor register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cursor_idx_q <= DEF_LVL;
        else     cursor_idx_q <= cursor_idx_d;
    end

    assign cursor_idx = cursor_idx_q;
`endif

    assign selected_level = selected_level_q;
    assign num_of_cards   = num_of_cards_q;
    assign level_changed  = level_changed_q;
    assign hover_valid    = hover_valid_q;
    assign hover_idx      = hover_idx_q;

endmodule

// File: tb/tb_options_menu_ctl.sv
module tb_options_menu_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [2:0]  selected_level;
    logic [5:0]  num_of_cards;
    logic        level_changed;
    logic        hover_valid;
    logic [2:0]  hover_idx;
    logic        pressed_idx_valid;
`ifdef OPTIONS_KEYS_EN
    logic        key_up, key_down, key_enter;
    logic [2:0]  cursor_idx;
`endif

    int errors = 0;
    int checks = 0;

    options_menu_ctl dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .mouse_left        (mouse_left),
        .mouse_xpos        (mouse_xpos),
        .mouse_ypos        (mouse_ypos),
`ifdef OPTIONS_KEYS_EN
        .key_up            (key_up),
        .key_down          (key_down),
        .key_enter         (key_enter),
        .cursor_idx        (cursor_idx),
`endif
        .selected_level    (selected_level),
        .num_of_cards      (num_of_cards),
        .level_changed     (level_changed),
        .hover_valid       (hover_valid),
        .hover_idx         (hover_idx),
        .pressed_idx_valid (pressed_idx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle so the outputs can be sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic state_chk(input string tag, input int lvl, input int cards, input int lc, input int piv);
        check({tag, ".lvl"}, 32'(selected_level), 32'(lvl));
        check({tag, ".cards"}, 32'(num_of_cards), 32'(cards));
        check({tag, ".lc"}, 32'(level_changed), 32'(lc));
        check({tag, ".piv"}, 32'(pressed_idx_valid), 32'(piv));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mouse_left = 1'b0; mouse_xpos = 12'd0; mouse_ypos = 12'd0;
`ifdef OPTIONS_KEYS_EN
        key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
`endif
        tick(); tick();
        state_chk("reset", 1, 12, 0, 0);
        check("reset.hv", 32'(hover_valid), 0);
        check("reset.hi", 32'(hover_idx), 0);
        rst = 1'b0;

        // Click button 0 and release inside it.
        enable = 1'b1; mouse_xpos = 12'd300; mouse_ypos = 12'd160;
        tick();
        check("t2.hv", 32'(hover_valid), 1);
        check("t2.hi", 32'(hover_idx), 0);
        mouse_left = 1'b1; tick();
        state_chk("t2.hold", 1, 12, 0, 1);
        mouse_ypos = 12'd170; mouse_left = 1'b0; tick();
        state_chk("t2.commit", 0, 8, 1, 0);
        tick();
        state_chk("t2.after", 0, 8, 0, 0);

        // Press button 2, drag to button 1, then release: no commit.
        mouse_ypos = 12'd320; mouse_left = 1'b1; tick();
        check("t3.piv", 32'(pressed_idx_valid), 1);
        check("t3.hi2", 32'(hover_idx), 2);
        mouse_ypos = 12'd240; tick();
        check("t3.drag.piv", 32'(pressed_idx_valid), 1);
        check("t3.hi1", 32'(hover_idx), 1);
        mouse_left = 1'b0; tick();
        state_chk("t3.rel", 0, 8, 0, 0);
        tick();
        check("t3.after.lc", 32'(level_changed), 0);

        // Button already held when enable rises: no arming until a fresh press.
        enable = 1'b0; mouse_ypos = 12'd320; mouse_left = 1'b1; tick();
        check("t4.hv_off", 32'(hover_valid), 0);
        enable = 1'b1; tick();
        check("t4.held.piv", 32'(pressed_idx_valid), 0);
        check("t4.hv", 32'(hover_valid), 1);
        mouse_left = 1'b0; tick();
        state_chk("t4.norel", 0, 8, 0, 0);
        mouse_left = 1'b1; tick();
        check("t4.arm", 32'(pressed_idx_valid), 1);
        mouse_left = 1'b0; tick();
        state_chk("t4.commit", 2, 16, 1, 0);
        tick();
        check("t4.pulse1", 32'(level_changed), 0);

        // Re-clicking the current level: no pulse.
        mouse_left = 1'b1; tick();
        mouse_left = 1'b0; tick();
        state_chk("t4.reclick", 2, 16, 0, 0);

        // Press on the gap, then move onto button 0 and release: ignored.
        mouse_ypos = 12'd215; mouse_left = 1'b1; tick();
        check("t5.gap.piv", 32'(pressed_idx_valid), 0);
        check("t5.gap.hv", 32'(hover_valid), 0);
        mouse_ypos = 12'd160; tick();
        check("t5.move.piv", 32'(pressed_idx_valid), 0);
        mouse_left = 1'b0; tick();
        state_chk("t5.rel", 2, 16, 0, 0);

        // Dropping enable during ARMED cancels the click.
        mouse_left = 1'b1; tick();
        check("t5.arm", 32'(pressed_idx_valid), 1);
        enable = 1'b0; tick();
        check("t5.cancel.piv", 32'(pressed_idx_valid), 0);
        check("t5.cancel.hv", 32'(hover_valid), 0);
        enable = 1'b1; mouse_left = 1'b0; tick();
        state_chk("t5.cancelrel", 2, 16, 0, 0);

        // Hit-test boundaries: bottom-right pixel of button 2, and one pixel beyond it.
        mouse_xpos = 12'd439; mouse_ypos = 12'd369; tick();
        check("b.in.hv", 32'(hover_valid), 1);
        check("b.in.hi", 32'(hover_idx), 2);
        mouse_xpos = 12'd440; tick();
        check("b.outx.hv", 32'(hover_valid), 0);
        check("b.outx.hi", 32'(hover_idx), 0);
        mouse_xpos = 12'd200; mouse_ypos = 12'd370; tick();
        check("b.outy.hv", 32'(hover_valid), 0);

        // Reset while ARMED goes back to the default level, with no pulse.
        mouse_ypos = 12'd150; mouse_left = 1'b1; tick();
        check("r.arm", 32'(pressed_idx_valid), 1);
        #2 rst = 1'b1; #1;
        state_chk("r.async", 1, 12, 0, 0);
        mouse_left = 1'b0; tick();
        rst = 1'b0; tick();
        state_chk("r.after", 1, 12, 0, 0);

`ifdef OPTIONS_KEYS_EN
        // Keyboard navigation: cursor starts at 1; up twice wraps to 2.
        mouse_xpos = 12'd0; mouse_ypos = 12'd0;
        check("k.cur.rst", 32'(cursor_idx), 1);
        key_up = 1'b1; tick(); key_up = 1'b0;
        check("k.cur0", 32'(cursor_idx), 0);
        key_up = 1'b1; tick(); key_up = 1'b0;
        check("k.cur2", 32'(cursor_idx), 2);
        key_enter = 1'b1; tick(); key_enter = 1'b0;
        state_chk("k.enter", 2, 16, 1, 0);
        key_enter = 1'b1; tick(); key_enter = 1'b0;
        state_chk("k.enter2", 2, 16, 0, 0);
        key_down = 1'b1; tick(); key_down = 1'b0;
        check("k.wrapdown", 32'(cursor_idx), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
